// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between the host loader, the LSU data port
// and instruction fetch (host > data > fetch), with a starvation override for fetch.
module mem_arbiter #(
  parameter int AW     = 9,
  parameter int DW     = 32,
  parameter int STARVE = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  input  logic          dat_req,
  input  logic          dat_we,
  input  logic [AW-1:0] dat_addr,
  input  logic [DW-1:0] dat_wdata,
  output logic          dat_gnt,
  output logic          dat_rvalid,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          if_stall
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DAT  = 2'd1,
    TAG_IF   = 2'd2
  } tag_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE);

  if (STARVE < 1 || STARVE > 15) begin : g_bad_starve
    $error("mem_arbiter: STARVE must be in 1..15");
  end

  tag_t       tag;
  logic [3:0] wait_cnt;
  logic       starved;

  assign starved = (wait_cnt == STARVE_LIM);

  // Host is never overridden; a starved fetch jumps ahead of data only.
  always_comb begin
    host_gnt = 1'b0;
    dat_gnt  = 1'b0;
    if_gnt   = 1'b0;
    if (!reset) begin
      if (host_req) begin
        host_gnt = 1'b1;
      end else if (if_req && (starved || !dat_req)) begin
        if_gnt = 1'b1;
      end else if (dat_req) begin
        dat_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (host_gnt) begin
      ram_addr  = host_addr;
      ram_we    = 1'b1;
      ram_wdata = host_wdata;
    end else if (dat_gnt) begin
      ram_addr  = dat_addr;
      ram_we    = dat_we;
      ram_wdata = dat_wdata;
    end else if (if_gnt) begin
      ram_addr  = if_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag      <= TAG_NONE;
      wait_cnt <= '0;
    end else begin
      if (dat_gnt && !dat_we) begin
        tag <= TAG_DAT;
      end else if (if_gnt) begin
        tag <= TAG_IF;
      end else begin
        tag <= TAG_NONE;
      end

      if (!if_req || if_gnt) begin
        wait_cnt <= '0;
      end else if (!starved) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  // Gating with reset drops a read whose grant landed just before reset asserted.
  assign dat_rvalid = (tag == TAG_DAT) && !reset;
  assign if_rvalid  = (tag == TAG_IF) && !reset;
  assign rdata      = ram_rdata;
  assign if_stall   = if_req && !if_gnt && !reset;

endmodule
